// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the 12-bit CPU fetch path: instruction width, opcodes, fetch FSM states.
package instr_fetch_queue_pkg;

    localparam int CPU_IW = 12;
    localparam int OPW    = 3;

    typedef enum logic [OPW-1:0] {
        OP_HALT = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_IMUL = 3'b100,
        OP_FADD = 3'b101,
        OP_FMUL = 3'b110,
        OP_CMP  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fq_state_t;

    function automatic logic is_halt(input logic [OPW-1:0] op);
        return op == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Generic DEPTH x W FIFO with wrapping pointers; head word shown combinationally (0 when empty).
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full (registered count); pop is ignored when empty.
module instr_fetch_queue_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed through count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: host-loaded program memory, PC stepper and prefetch FIFO feeding the CPU.
// Latency: start -> FETCH next cycle -> first instruction valid the cycle after.
// Backpressure: instr_ready low holds the head; a full FIFO stalls the PC and the FSM.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int IW    = CPU_IW,
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    logic [IW-1:0] prog_mem [2**AW];
    fq_state_t     state;
    fq_state_t     state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [IW-1:0] word;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          load_ok;

    assign word        = prog_mem[pc];
    assign load_ok     = load_en && (state == ST_IDLE || state == ST_HALT);
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready;
    assign busy        = (state == ST_FETCH) || (state == ST_DRAIN);
    assign halted      = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (load_ok) prog_mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = '0;
                end
            end
            ST_FETCH: begin
                if (!fifo_full) begin
                    if (is_halt(word[IW-1 -: OPW])) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        push = 1'b1;
                        // Last address ends the program instead of wrapping to 0.
                        if (pc == {AW{1'b1}}) state_nxt = ST_DRAIN;
                        else                  pc_nxt    = pc + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) state_nxt = ST_HALT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    instr_fetch_queue_fifo #(
        .W     (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (word),
        .pop      (pop),
        .head_dat (instr_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue; expected stream is derived from a copy of the program image.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [11:0] load_data;
    logic        start;
    logic [11:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;

    logic [11:0] model_mem [16];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [11:0] d, input bit honoured);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
        if (honoured) model_mem[a] = d;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [11:0] rand_op();
        return 12'($urandom_range(12'h200, 12'hFFF));
    endfunction

    // Program semantics: words from address 0 up to the first HALT opcode or the end of memory.
    task automatic expected_stream(output logic [11:0] q[$]);
        q = {};
        for (int i = 0; i < 16; i++) begin
            if (model_mem[i][11:9] == 3'b000) break;
            q.push_back(model_mem[i]);
        end
    endtask

    task automatic drain(input int rdy_pct, input string tag);
        logic [11:0] exp_q[$];
        logic [11:0] prev = '0;
        logic        prev_stall = 1'b0;
        int          n = 0;
        int          cyc = 0;
        expected_stream(exp_q);
        while (!halted && cyc < 400) begin
            if (prev_stall) chk({tag, " hold"}, instr_out, prev);
            instr_ready = ($urandom_range(0, 99) < rdy_pct);
            if (instr_valid && instr_ready) begin
                if (n < exp_q.size()) chk({tag, " word"}, instr_out, exp_q[n]);
                else                  chk({tag, " extra"}, n, exp_q.size());
                n++;
            end
            prev_stall = instr_valid && !instr_ready;
            prev       = instr_out;
            step();
            cyc++;
        end
        chk({tag, " halted"}, halted, 1);
        chk({tag, " count"}, n, exp_q.size());
        chk({tag, " busy"}, busy, 0);
        chk({tag, " valid"}, instr_valid, 0);
        instr_ready = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int cyc = 0;
        while (!halted && cyc < 50) begin
            step();
            cyc++;
        end
        chk(tag, halted, 1);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        step();
        step();
        chk("rst valid", instr_valid, 0);
        chk("rst out", instr_out, 0);
        chk("rst busy", busy, 0);
        chk("rst halted", halted, 0);
        chk("rst pc", pc, 0);
        rst = 1'b0;
        step();
        chk("idle busy", busy, 0);

        // Short program with handshake latency
        load(4'd0, 12'h281, 1);
        load(4'd1, 12'h4C1, 1);
        load(4'd2, 12'h000, 1);
        instr_ready = 1'b1;
        start_pulse();
        chk("lat c1 valid", instr_valid, 0);
        chk("lat c1 busy", busy, 1);
        step();
        chk("lat c2 valid", instr_valid, 1);
        chk("lat c2 out", instr_out, 12'h281);
        step();
        chk("lat c3 out", instr_out, 12'h4C1);
        step();
        chk("lat c4 valid", instr_valid, 0);
        wait_halt("short halted");
        instr_ready = 1'b0;

        // Backpressure: FIFO fills, PC stalls, head stays put
        load(4'd0, 12'h281, 1);
        for (int i = 1; i < 8; i++) load(4'(i), rand_op(), 1);
        load(4'd8, {3'b000, 9'($urandom)}, 1);
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall head", instr_out, 12'h281);
        end
        chk("stall pc", pc, 4);
        chk("stall valid", instr_valid, 1);
        drain(100, "stall");

        // Start during FETCH is ignored; start from HALT replays
        start_pulse();
        for (int i = 0; i < 6; i++) step();
        chk("restart pc before", pc, 4);
        start_pulse();
        chk("restart pc after", pc, 4);
        chk("restart busy", busy, 1);
        drain(100, "restart");
        start_pulse();
        drain(50, "replay");

        // Full memory, no HALT: exactly 16 out, no wrap
        for (int i = 0; i < 16; i++) load(4'(i), rand_op(), 1);
        start_pulse();
        drain(70, "full");
        chk("full pc end", pc, 15);

        // Load while busy is ignored
        start_pulse();
        step();
        load(4'd1, 12'hFFF, 0);
        drain(100, "busyload");
        start_pulse();
        drain(60, "busyload rerun");

        // Reset mid-run
        start_pulse();
        step();
        step();
        chk("mid valid pre", instr_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid rst valid", instr_valid, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst pc", pc, 0);
        step();
        rst = 1'b0;
        step();
        chk("mid rst halted", halted, 0);
        start_pulse();
        drain(80, "after rst");

        // Random programs with scattered HALT words and random ready
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 5) == 0) load(4'(i), {3'b000, 9'($urandom)}, 1);
                else                            load(4'(i), rand_op(), 1);
            end
            start_pulse();
            drain(int'($urandom_range(30, 100)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
